// File: rtl/ip_stack_axis_pkg.sv
// Shared definitions for the AXI-Stream ingress blocks: frame state
// encoding and the frame-boundary next-state helper.
package ip_stack_axis_pkg;

  // Byte lane width used to size tkeep
  localparam int BYTE_BITS = 8;

  // One-hot style encoding, shared with other blocks that decode it
  typedef enum logic [7:0] {
    IDLE     = 8'h01,
    IN_FRAME = 8'h02,
    DROP     = 8'h04
  } frame_state_e;

  // Next frame state for one clock edge.
  //   beat       : a beat is accepted on this edge
  //   last       : that beat closes its frame
  //   drop_start : a frame starting on this beat is to be discarded
  // A single-beat frame (first beat is also last) never leaves IDLE,
  // whether it is kept or dropped.
  function automatic frame_state_e frame_next_state(
    input frame_state_e state,
    input logic         beat,
    input logic         last,
    input logic         drop_start
  );
    frame_state_e next;
    next = state;
    case (state)
      IDLE: begin
        if (beat && !last) begin
          next = drop_start ? DROP : IN_FRAME;
        end
      end
      IN_FRAME, DROP: begin
        if (beat && last) begin
          next = IDLE;
        end
      end
      default: next = IDLE;
    endcase
    return next;
  endfunction

  // True when a beat accepted in this state must not reach the FIFO
  function automatic logic frame_discards_beat(
    input frame_state_e state,
    input logic         drop_start
  );
    return (state == DROP) || ((state == IDLE) && drop_start);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry elastic buffer: an output register (OUT) feeding the sink and
// a skid register (SKID) that absorbs the one extra beat that can arrive
// while the registered ready is still high. The upstream ready is
// registered and means "SKID will be empty after this edge".
module axis_skid_buffer #(
  parameter int WIDTH = 513
) (
  input  logic             clock,
  input  logic             reset,
  // Upstream side: push_i is only asserted while ready_o is high
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  // Forces ready_o high for the next cycle (beats are being discarded)
  input  logic             hold_ready_i,
  output logic             ready_o,
  // Downstream side: OUT drains on any cycle where pop_ready_i is high
  input  logic             pop_ready_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o
);

  logic             out_valid_q;
  logic             out_valid_d;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] out_data_d;
  logic             skid_valid_q;
  logic             skid_valid_d;
  logic [WIDTH-1:0] skid_data_q;
  logic [WIDTH-1:0] skid_data_d;
  logic             ready_q;
  logic             drain;

  // OUT leaves the buffer this cycle
  assign drain = out_valid_q && pop_ready_i;

  // Next-state of both entries: OUT refills from SKID first, then from
  // the incoming beat; SKID only fills when OUT is occupied and stalled.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (drain || !out_valid_q) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = push_i;
        if (push_i) begin
          skid_data_d = data_i;
        end
      end else begin
        out_valid_d = push_i;
        if (push_i) begin
          out_data_d = data_i;
        end
      end
    end else if (push_i) begin
      skid_valid_d = 1'b1;
      skid_data_d  = data_i;
    end
  end

  // Register both entries and the upstream ready
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= hold_ready_i || !skid_valid_d;
    end
  end

  assign ready_o     = ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/axis_to_fifo.sv
// AXI-Stream to FIFO write-port bridge. Beats pass through a two-entry
// skid buffer so tready_out can be registered while the FIFO's full flag
// is honoured combinationally. A frame tracker counts completed frames.
// Optional feature, enabled by defining AXIS_TO_FIFO_DROP_EN: a frame
// whose first beat arrives while fifo_almost_full is high is discarded
// in full and counted in drop_count.
module axis_to_fifo
  import ip_stack_axis_pkg::*;
#(
  parameter int DATA_SIZE   = 512,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  // AXI-Stream slave
  input  logic                           tvalid_in,
  output logic                           tready_out,
  input  logic [DATA_SIZE-1:0]           tdata_in,
  input  logic                           tlast_in,
  input  logic [DATA_SIZE/BYTE_BITS-1:0] tkeep_in,
  // FIFO write port
  output logic                           fifo_write_enable,
  output logic [DATA_SIZE-1:0]           fifo_data_in,
  output logic                           fifo_last_in,
  input  logic                           fifo_full,
  input  logic                           fifo_almost_full,
  // Statistics
  output logic [COUNT_WIDTH-1:0]         frame_count,
  output logic [COUNT_WIDTH-1:0]         drop_count
);

  frame_state_e           state_q;
  frame_state_e           state_d;
  logic                   accept;
  logic                   almost_full_eff;
  logic                   discard;
  logic                   push;
  logic                   hold_ready;
  logic                   out_valid;
  logic [DATA_SIZE:0]     out_data;
  logic [COUNT_WIDTH-1:0] frame_count_q;

  // Byte enables are carried on the bus but the FIFO stores no keep lane
  logic unused_tkeep;
  assign unused_tkeep = ^tkeep_in;

  assign accept  = tvalid_in && tready_out;
  assign discard = frame_discards_beat(state_q, almost_full_eff);
  assign push    = accept && !discard;
  assign state_d = frame_next_state(state_q, accept, tlast_in, almost_full_eff);

  // While a frame is being discarded nothing enters the buffer, so the
  // upstream can be kept flowing regardless of FIFO back-pressure.
  assign hold_ready = (state_d == DROP);

  axis_skid_buffer #(
    .WIDTH (DATA_SIZE + 1)
  ) u_skid (
    .clock        (clock),
    .reset        (reset),
    .push_i       (push),
    .data_i       ({tlast_in, tdata_in}),
    .hold_ready_i (hold_ready),
    .ready_o      (tready_out),
    .pop_ready_i  (!fifo_full),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data)
  );

  assign fifo_write_enable            = out_valid && !fifo_full;
  assign {fifo_last_in, fifo_data_in} = out_data;

  // Frame tracker: advances only on accepted beats
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Completed-frame counter: a frame is complete when its last beat is
  // written into the FIFO; wraps naturally at the counter width
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_count_q <= '0;
    end else if (fifo_write_enable && fifo_last_in) begin
      frame_count_q <= frame_count_q + COUNT_WIDTH'(1);
    end
  end

  assign frame_count = frame_count_q;

`ifdef AXIS_TO_FIFO_DROP_EN
  logic [COUNT_WIDTH-1:0] drop_count_q;

  assign almost_full_eff = fifo_almost_full;

  // Dropped-frame counter: one count per discarded frame, taken at its
  // first beat
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count_q <= '0;
    end else if (accept && (state_q == IDLE) && almost_full_eff) begin
      drop_count_q <= drop_count_q + COUNT_WIDTH'(1);
    end
  end

  assign drop_count = drop_count_q;
`else
  // Without the drop feature every frame is written; the threshold flag
  // has no effect
  logic unused_almost_full;
  assign unused_almost_full = fifo_almost_full;
  assign almost_full_eff    = 1'b0;
  assign drop_count         = '0;
`endif

endmodule

// File: doc/axis_to_fifo.md
AXIS_TO_FIFO -- requirements
Module: axis_to_fifo

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 512, giving the data width in bits (multiple of 8).
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, giving the width of the statistics counters.
REQ-003 SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port tvalid_in, input, 1 bit: AXIS beat valid.
REQ-006 SHALL have port tready_out, output, 1 bit: AXIS ready, registered.
REQ-007 SHALL have port tdata_in, input, DATA_SIZE bits: AXIS data.
REQ-008 SHALL have port tlast_in, input, 1 bit: last beat of the frame.
REQ-009 SHALL have port tkeep_in, input, DATA_SIZE/8 bits: byte enables (captured, not interpreted).
REQ-010 SHALL have port fifo_write_enable, output, 1 bit: FIFO write strobe.
REQ-011 SHALL have port fifo_data_in, output, DATA_SIZE bits: FIFO write data.
REQ-012 SHALL have port fifo_last_in, output, 1 bit: end-of-frame flag stored alongside the data.
REQ-013 SHALL have port fifo_full, input, 1 bit: FIFO cannot accept a write this cycle.
REQ-014 SHALL have port fifo_almost_full, input, 1 bit: FIFO is at or above its programmed threshold.
REQ-015 SHALL have port frame_count, output, COUNT_WIDTH bits: frames fully written to the FIFO.
REQ-016 SHALL have port drop_count, output, COUNT_WIDTH bits: frames discarded (held at 0 without the drop feature).

Function
REQ-017 SHALL accept a beat on a clock edge where tvalid_in && tready_out.
REQ-018 SHALL hold data in a two-entry buffer: an output register (OUT) and a skid register (SKID).
REQ-019 SHALL place an accepted beat in OUT when OUT is empty or draining this cycle, otherwise in SKID.
REQ-020 SHALL drive fifo_write_enable = OUT valid && !fifo_full (combinational from registers and fifo_full).
REQ-021 SHALL drive fifo_data_in and fifo_last_in directly from OUT.
REQ-022 SHALL give a latency of 1 cycle: a beat accepted at edge N appears at OUT in cycle N+1.
REQ-023 SHALL, when SKID is valid and OUT drains, move SKID into OUT on that edge.
REQ-024 SHALL register tready_out as 1 exactly when SKID will be empty after the current edge.
REQ-025 SHALL lose no beat and duplicate no beat under any tvalid_in/fifo_full pattern.
REQ-026 SHALL implement a frame state machine with states IDLE, IN_FRAME and DROP.
REQ-027 SHALL transition IDLE->IN_FRAME on an accepted beat with tlast_in=0.
REQ-028 SHALL remain in IDLE on an accepted beat with tlast_in=1 (single-beat frame).
REQ-029 SHALL transition IN_FRAME->IDLE on an accepted beat with tlast_in=1.
REQ-030 SHALL increment frame_count on each fifo_write_enable with fifo_last_in=1, wrapping modulo 2^COUNT_WIDTH.
REQ-031 SHALL, when fifo_full holds continuously, deassert tready_out after at most two accepted beats.

Reset
REQ-032 SHALL, on reset, set OUT and SKID invalid, tready_out=0, fifo_write_enable=0, fifo_data_in=0, fifo_last_in=0, state=IDLE, frame_count=0 and drop_count=0.
REQ-033 SHALL assert tready_out on the first cycle after reset deasserts.
REQ-034 SHALL, on reset mid-frame, discard buffered beats; the FIFO's partial frame is the FIFO owner's responsibility.

Configuration
REQ-035 SHALL, with macro AXIS_TO_FIFO_DROP_EN defined, discard the whole frame when its first beat is accepted while fifo_almost_full=1: enter DROP (or stay IDLE if tlast_in=1), write no beats of the frame, and increment drop_count once.
REQ-036 SHALL, in DROP, hold tready_out=1, discard every beat, and return to IDLE on the tlast_in beat.
REQ-037 SHALL, with macro AXIS_TO_FIFO_DROP_EN undefined, never drop a frame: there is no DROP state, drop_count is held at 0, and fifo_almost_full is ignored.

Structure
REQ-038 SHALL place the state encoding (IDLE=8'h01, IN_FRAME=8'h02, DROP=8'h04) in a shared package ip_stack_axis_pkg.
REQ-039 SHALL implement the two-entry buffer as sub-module axis_skid_buffer, parameterised by DATA_SIZE+1 bits.

Verification
REQ-040 SHALL cover: a 4-beat frame with fifo_full=0 -> four writes on consecutive cycles one cycle after acceptance, fifo_last_in on the 4th write, frame_count=1.
REQ-041 SHALL cover: fifo_full=1 for 5 cycles mid-frame -> tready_out low within 2 accepted beats, no beat lost, data order preserved.
REQ-042 SHALL cover: a single-beat frame with tlast_in=1 -> one write with fifo_last_in=1, state stays IDLE.
REQ-043 SHALL cover, with AXIS_TO_FIFO_DROP_EN: fifo_almost_full=1 at the first beat of a 3-beat frame -> zero writes, drop_count=1, and the next frame written normally.
REQ-044 SHALL cover: reset asserted on the 2nd beat of a frame -> all outputs at reset values next cycle, tready_out=1 one cycle after release.
REQ-045 SHALL cover: frame_count preloaded to 16'hFFFF by forcing, then one frame -> frame_count=0.
